// File: rtl/cache_pkg.sv
// Shared types and default sizing for the L1 cache port arbiter.
package cache_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned MM_BLOCK_COUNT = 1024;
  localparam int unsigned ADDR_BITS      = $clog2(MM_BLOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    REFILL,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_BITS-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cache_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant; search starts one past the last granted requester.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_grant
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (en && !any_grant && req_valid[cand]) begin
        any_grant       = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= IDX_W'(NUM_REQ - 1);
    else if (any_grant)
      last_grant <= grant_idx;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Arbitrates requesters onto the single cache port, replays read misses after
// a refill cycle, and returns a one-cycle response to the owning requester.
module cache_port_arbiter #(
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned MM_BLOCK_COUNT = 1024,
  parameter  int unsigned NUM_REQ        = 2,
  parameter  int unsigned MAX_REPLAY     = 2,
  localparam int unsigned ADDR_BITS      = $clog2(MM_BLOCK_COUNT)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_rw,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic                                rsp_err,
  output logic                                c_en,
  output logic                                c_rw,
  output logic [ADDR_BITS-1:0]                c_addr,
  output logic [DATA_WIDTH-1:0]               c_wdata,
  input  logic [DATA_WIDTH-1:0]               c_rdata,
  input  logic                                c_hit
);

  import cache_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned RC_W  = $clog2(MAX_REPLAY + 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] grant_idx;
  logic [RC_W-1:0]  replay_cnt;
  logic             replay_done;
  logic             arb_en;
  logic             accept;

  assign arb_en      = !reset && (state == IDLE || state == RESP);
  assign replay_done = (replay_cnt == RC_W'(MAX_REPLAY));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .any_grant (accept)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    c_en      = 1'b0;
    rsp_valid = '0;
    case (state)
      IDLE:   if (accept) state_nxt = ACCESS;
      ACCESS: begin
        c_en = 1'b1;
        if (c_rw || c_hit || replay_done) state_nxt = RESP;
        else                              state_nxt = REFILL;
      end
      REFILL: state_nxt = ACCESS;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        state_nxt        = accept ? ACCESS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= '0;
      replay_cnt <= '0;
      c_rw       <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant_idx;
        c_rw       <= req_rw[grant_idx];
        c_addr     <= req_addr[grant_idx];
        c_wdata    <= req_wdata[grant_idx];
        replay_cnt <= '0;
      end
      if (state == REFILL && !replay_done)
        replay_cnt <= replay_cnt + 1'b1;
      // A hit on the last allowed replay still succeeds; only a miss there errors.
      if (state == ACCESS) begin
        if (c_rw) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end else if (c_hit) begin
          rsp_rdata <= c_rdata;
          rsp_err   <= 1'b0;
        end else if (replay_done) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level timeline model.
module tb_cache_port_arbiter;

  localparam int NR = 2;
  localparam int MR = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_rw;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdata;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          rsp_valid;
  logic [DW-1:0]          rsp_rdata;
  logic                   rsp_err;
  logic                   c_en;
  logic                   c_rw;
  logic [AW-1:0]          c_addr;
  logic [DW-1:0]          c_wdata;
  logic [DW-1:0]          c_rdata;
  logic                   c_hit;

  always #5 clk = ~clk;

  cache_port_arbiter #(
    .DATA_WIDTH     (DW),
    .MM_BLOCK_COUNT (1024),
    .NUM_REQ        (NR),
    .MAX_REPLAY     (MR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .c_en      (c_en),
    .c_rw      (c_rw),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_hit     (c_hit)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            misses;
    logic [DW-1:0] rdata;
    logic [NR-1:0] exp_ready;
    int            exp_acc;
    int            exp_lat;
    logic [NR-1:0] exp_rsp;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    bit            chk_rdata;
  } vec_t;

  vec_t tbl[6];
  vec_t post;

  // Enters and leaves at posedge+1 with the DUT idle.
  task automatic run_txn(input vec_t v);
    int acc;
    int lat;
    req_valid    = v.valid;
    req_rw       = {NR{v.rw}};
    req_addr[0]  = v.addr;
    req_addr[1]  = v.addr;
    req_wdata[0] = v.wdata;
    req_wdata[1] = v.wdata;
    c_hit        = 1'b0;
    #1;
    chk("accept_ready", 64'(req_ready), 64'(v.exp_ready));
    @(posedge clk); #1;
    req_valid = '0;
    acc = 0;
    lat = 0;
    for (int k = 1; k <= 24 && lat == 0; k++) begin
      c_hit   = (acc >= v.misses);
      c_rdata = v.rdata;
      #1;
      if (c_en) begin
        chk("c_rw", 64'(c_rw), 64'(v.rw));
        chk("c_addr", 64'(c_addr), 64'(v.addr));
        chk("c_wdata", 64'(c_wdata), 64'(v.wdata));
        acc++;
      end
      if (rsp_valid != '0) begin
        lat = k;
        chk("rsp_valid", 64'(rsp_valid), 64'(v.exp_rsp));
        chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
        if (v.chk_rdata) chk("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
      end
      @(posedge clk); #1;
    end
    chk("rsp_latency", 64'(lat), 64'(v.exp_lat));
    chk("c_en_count", 64'(acc), 64'(v.exp_acc));
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int lg);
    for (int k = 1; k <= NR; k++) begin
      if (v[(lg + k) % NR]) return (lg + k) % NR;
    end
    return -1;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid  rw  addr    wdata         miss rdata         ready acc lat rsp   exp_rdata     err chk
    tbl[0] = '{2'b11, 1'b0, 10'h005, 32'h0,        0, 32'hDEADBEEF, 2'b01, 1, 2, 2'b01, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[1] = '{2'b10, 1'b0, 10'h3C5, 32'h0,        1, 32'h12345678, 2'b10, 2, 4, 2'b10, 32'h12345678, 1'b0, 1'b1};
    tbl[2] = '{2'b01, 1'b1, 10'h040, 32'hCAFEF00D, 7, 32'h55555555, 2'b01, 1, 2, 2'b01, 32'h0,        1'b0, 1'b1};
    tbl[3] = '{2'b11, 1'b0, 10'h123, 32'h0,        7, 32'h11112222, 2'b10, 3, 6, 2'b10, 32'h0,        1'b1, 1'b0};
    tbl[4] = '{2'b11, 1'b0, 10'h3FF, 32'h0,        2, 32'hA5A5A5A5, 2'b01, 3, 6, 2'b01, 32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[5] = '{2'b11, 1'b1, 10'h000, 32'hFFFFFFFF, 0, 32'h77777777, 2'b10, 1, 2, 2'b10, 32'h0,        1'b0, 1'b1};
    post   = '{2'b11, 1'b0, 10'h155, 32'h0,        0, 32'h0BADCAFE, 2'b01, 1, 2, 2'b01, 32'h0BADCAFE, 1'b0, 1'b1};

    reset     = 1'b1;
    req_valid = 2'b11;
    req_rw    = '0;
    req_addr  = '0;
    req_wdata = '0;
    c_rdata   = '0;
    c_hit     = 1'b0;

    // Reset held two cycles with both requesters asking.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset_ready", 64'(req_ready), 64'(0));
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_c_en", 64'(c_en), 64'(0));
      chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("reset_rsp_err", 64'(rsp_err), 64'(0));
      chk("reset_c_addr", 64'(c_addr), 64'(0));
    end
    reset     = 1'b0;
    req_valid = '0;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset while in REFILL drops the request.
    req_valid = 2'b01;
    req_rw    = 2'b00;
    req_addr[0] = 10'h2AA;
    c_hit     = 1'b0;
    #1;
    chk("midreset_accept", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    chk("midreset_access", 64'(c_en), 64'(1));
    @(posedge clk); #1;
    chk("midreset_refill_c_en", 64'(c_en), 64'(0));
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("midreset_ready_in_reset", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;
    #1;
    chk("midreset_c_en_after", 64'(c_en), 64'(0));
    chk("midreset_c_addr_after", 64'(c_addr), 64'(0));
    for (int i = 0; i < 6; i++) begin
      chk("midreset_no_rsp", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
    end
    run_txn(post);

    // Fairness: both requesters always valid, all hits.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int g;
      int last_cyc;
      int last_g;
      g = 0;
      last_cyc = 0;
      last_g = 0;
      req_valid = 2'b11;
      req_rw    = 2'b00;
      c_hit     = 1'b1;
      for (int cyc = 0; cyc < 40 && g < 8; cyc++) begin
        c_rdata = $urandom;
        #1;
        if (req_ready != '0) begin
          chk("fair_grant", 64'(req_ready), 64'(1 << (g % 2)));
          if (g > 0) begin
            chk("fair_spacing", 64'(cyc - last_cyc), 64'(2));
            chk("fair_overlap_rsp", 64'(rsp_valid), 64'(1 << last_g));
          end
          last_cyc = cyc;
          last_g   = g % 2;
          g++;
        end
        @(posedge clk); #1;
      end
      chk("fair_grant_count", 64'(g), 64'(8));
      req_valid = '0;
    end

    // Randomized run against a timeline model.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int lg, owner, t_acc, rsp_c, nacc, m_plan, j, g;
      bit active, in_acc, m_rw, m_err;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_wdata, m_rdata;
      logic [NR-1:0] exp_rsp;
      lg = NR - 1;
      active = 0;
      owner = 0; t_acc = 0; rsp_c = 0; nacc = 0; m_plan = 0;
      m_rw = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        in_acc = active && cyc > t_acc && cyc < rsp_c && ((cyc - t_acc - 1) % 2 == 0);
        j = (cyc - t_acc - 1) / 2;
        c_rdata = $urandom;
        if (in_acc) c_hit = m_rw ? 1'($urandom) : (j >= m_plan);
        else        c_hit = 1'($urandom);
        if (in_acc && !m_rw && !m_err && j == nacc - 1) m_rdata = c_rdata;
        req_valid = NR'($urandom_range(0, 3));
        for (int r = 0; r < NR; r++) begin
          req_rw[r]    = 1'($urandom);
          req_addr[r]  = AW'($urandom);
          req_wdata[r] = $urandom;
        end
        g = (!active || cyc == rsp_c) ? pick(req_valid, lg) : -1;
        #1;
        chk("rnd_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'(0));
        chk("rnd_c_en", 64'(c_en), 64'(in_acc));
        if (in_acc) begin
          chk("rnd_c_rw", 64'(c_rw), 64'(m_rw));
          chk("rnd_c_addr", 64'(c_addr), 64'(m_addr));
          chk("rnd_c_wdata", 64'(c_wdata), 64'(m_wdata));
        end
        exp_rsp = (active && cyc == rsp_c) ? NR'(1 << owner) : '0;
        chk("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (exp_rsp != '0) begin
          chk("rnd_rsp_err", 64'(rsp_err), 64'(m_err));
          if (!m_err) chk("rnd_rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        end
        if (active && cyc == rsp_c) active = 0;
        if (g >= 0) begin
          active  = 1;
          t_acc   = cyc;
          owner   = g;
          lg      = g;
          m_rw    = req_rw[g];
          m_addr  = req_addr[g];
          m_wdata = req_wdata[g];
          m_rdata = '0;
          m_plan  = $urandom_range(0, 3);
          m_err   = !m_rw && (m_plan > MR);
          nacc    = m_rw ? 1 : ((m_plan > MR) ? MR + 1 : m_plan + 1);
          rsp_c   = cyc + 2 * nacc;
        end
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
